audio_i2s_out: RTL and testbench



---
 rtl/audio_pkg.sv | 36 +++
 rtl/audio_clock_gen.sv | 51 +++++
 rtl/audio_i2s_out.sv | 104 ++++++++++
 tb/tb_audio_i2s_out.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg
// Shared constants and types for the I2S audio output path.
//   ACC_INC / ACC_MOD : fractional MCLK accumulator step and modulus
//                       (74.25 MHz * 245760 / 742500 = 2 * 12.288 MHz)
//   SAMPLE_W          : PCM bits per channel
//   SLOT_W            : SCLK slots per channel (LRCK half-period)
//   stereo_pair_t     : one left/right PCM pair
package audio_pkg;

  localparam int ACC_W      = 22;
  localparam int SAMPLE_W   = 16;
  localparam int SLOT_W     = 32;
  localparam int SLOT_CNT_W = $clog2(SLOT_W);

  localparam logic [ACC_W-1:0] ACC_INC = 22'd245760;
  localparam logic [ACC_W-1:0] ACC_MOD = 22'd742500;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_pair_t;

  // Serial bit for slot k of a channel: I2S places the MSB in slot 1
  // (one SCLK after the LRCK edge) and the LSB in slot 16; all other
  // slots carry zero.
  function automatic logic slot_bit(input logic [SAMPLE_W-1:0]   chan,
                                    input logic [SLOT_CNT_W-1:0] k);
    logic [SLOT_CNT_W-1:0] idx;
    idx = 5'd16 - k;
    if (k >= 5'd1 && k <= 5'd16)
      return chan[idx[3:0]];
    else
      return 1'b0;
  endfunction

endpackage

// File: rtl/audio_clock_gen.sv
// audio_clock_gen
// Derives the 12.288 MHz MCLK from clk_74a with a fractional accumulator
// and produces the single-cycle SCLK falling-edge strobe (MCLK / 4).
// Ports:
//   clock      in  74.25 MHz system clock
//   reset      in  asynchronous, active-high
//   audio_mclk out registered MCLK
//   sclk_fall  out one-cycle strobe, the cycle in which SCLK falls
module audio_clock_gen
  import audio_pkg::*;
(
  input  logic clock,
  input  logic reset,
  output logic audio_mclk,
  output logic sclk_fall
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic             wrap;
  logic             mclk_rise;
  logic [1:0]       div;

  // The accumulator never exceeds ACC_MOD-1 + ACC_INC, which fits in
  // 22 bits, so no carry-out is lost.
  always_comb begin
    acc_nxt   = acc + ACC_INC;
    wrap      = (acc_nxt >= ACC_MOD);
    mclk_rise = wrap && !audio_mclk;
    // SCLK is div[1]; it falls on the rise that takes div from 3 to 0.
    sclk_fall = mclk_rise && (div == 2'd3);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      audio_mclk <= 1'b0;
      div        <= 2'd0;
    end else begin
      if (wrap) begin
        acc        <= acc_nxt - ACC_MOD;
        audio_mclk <= ~audio_mclk;
      end else begin
        acc <= acc_nxt;
      end
      if (mclk_rise)
        div <= div + 2'd1;
    end
  end

endmodule

// File: rtl/audio_i2s_out.sv
// audio_i2s_out
// I2S transmitter for the Pocket scaler audio interface. Accepts 16-bit
// stereo PCM pairs over valid/ready into a one-deep holding register,
// loads them into the active pair at each frame start (LRCK 1->0) and
// shifts them out MSB first with the standard one-SCLK I2S delay.
// Ports:
//   clock        in  74.25 MHz system clock
//   reset        in  asynchronous, active-high
//   sample_left  in  signed PCM, left channel
//   sample_right in  signed PCM, right channel
//   sample_valid in  pair offered
//   sample_ready out holding register empty
//   mute         in  force DAC data to zero from the next slot
//   underrun     out one-cycle pulse, frame started with no new pair
//   audio_mclk   out 12.288 MHz
//   audio_lrck   out 0 = left, 1 = right
//   audio_dac    out serial data
module audio_i2s_out
  import audio_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_left,
  input  logic [SAMPLE_W-1:0] sample_right,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                mute,
  output logic                underrun,
  output logic                audio_mclk,
  output logic                audio_lrck,
  output logic                audio_dac
);

  logic                  sclk_fall;
  logic [SLOT_CNT_W-1:0] slot;
  logic [SLOT_CNT_W-1:0] slot_nxt;
  logic                  lrck_nxt;
  logic                  frame_start;
  logic                  take;
  logic                  hold_full;
  logic                  hold_full_nxt;
  stereo_pair_t          hold_q;
  stereo_pair_t          active_q;
  logic [SAMPLE_W-1:0]   chan;
  logic                  dac_nxt;

  audio_clock_gen u_clock_gen (
    .clock      (clock),
    .reset      (reset),
    .audio_mclk (audio_mclk),
    .sclk_fall  (sclk_fall)
  );

  always_comb begin
    slot_nxt    = slot + 5'd1;
    lrck_nxt    = (slot == 5'd31) ? ~audio_lrck : audio_lrck;
    frame_start = sclk_fall && (slot == 5'd31) && audio_lrck;
    take        = sample_valid && sample_ready;

    // Unload at frame start first, then capture, so a simultaneous
    // capture always leaves the holding register full.
    hold_full_nxt = hold_full;
    if (frame_start)
      hold_full_nxt = 1'b0;
    if (take)
      hold_full_nxt = 1'b1;

    // Channel follows the LRCK value of the slot being entered. At the
    // frame-start edge the slot entered is slot 0, which is always zero,
    // so using the pre-update active pair there is harmless.
    chan    = lrck_nxt ? active_q.right : active_q.left;
    dac_nxt = !mute && slot_bit(chan, slot_nxt);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot         <= '0;
      audio_lrck   <= 1'b0;
      audio_dac    <= 1'b0;
      underrun     <= 1'b0;
      sample_ready <= 1'b0;
      hold_full    <= 1'b0;
      hold_q       <= '0;
      active_q     <= '0;
    end else begin
      underrun  <= frame_start && !hold_full;
      hold_full <= hold_full_nxt;
      // Registered copy of !hold_full; held low while in reset.
      sample_ready <= !hold_full_nxt;

      if (frame_start && hold_full)
        active_q <= hold_q;
      if (take)
        hold_q <= stereo_pair_t'{left: sample_left, right: sample_right};

      if (sclk_fall) begin
        slot       <= slot_nxt;
        audio_lrck <= lrck_nxt;
        audio_dac  <= dac_nxt;
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_out.sv
module tb_audio_i2s_out;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_left = '0;
  logic [15:0] sample_right = '0;
  logic        sample_valid = 1'b0;
  logic        mute = 1'b0;
  logic        sample_ready;
  logic        underrun;
  logic        audio_mclk;
  logic        audio_lrck;
  logic        audio_dac;

  audio_i2s_out dut (
    .clock        (clock),
    .reset        (reset),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .mute         (mute),
    .underrun     (underrun),
    .audio_mclk   (audio_mclk),
    .audio_lrck   (audio_lrck),
    .audio_dac    (audio_dac)
  );

  always #7 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: clock tree expressed as closed-form counts since reset.
  longint n;
  logic   m_ready, m_hf, m_underrun, m_dac, m_xfer, m_fall, m_fs;
  logic [31:0] m_hold, m_active;
  int     m_k, m_lr;

  // Bookkeeping on DUT outputs
  logic [15:0] cap;
  logic [15:0] last_left;
  logic [31:0] played[$];
  int zero_slot_ones, ur_count, mclk_rises, lrck_falls, dac_ones;
  logic prev_mclk, prev_lrck;

  function automatic longint toggles(input longint c);
    return (c * 64'd245760) / 64'd742500;
  endfunction

  function automatic longint sfalls(input longint c);
    return ((toggles(c) + 1) / 2) / 4;
  endfunction

  task automatic model_reset();
    n = 0; m_ready = 0; m_hf = 0; m_hold = '0; m_active = '0;
    m_dac = 0; m_underrun = 0; m_xfer = 0; m_fall = 0; m_fs = 0;
    m_k = 0; m_lr = 0;
    prev_mclk = 0; prev_lrck = 0; cap = '0;
  endtask

  task automatic clear_stats();
    played.delete();
    zero_slot_ones = 0; ur_count = 0; mclk_rises = 0; lrck_falls = 0; dac_ones = 0;
  endtask

  task automatic step();
    longint sp, sn;
    logic [15:0] chan;
    logic [4:0]  exp;
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      sp = sfalls(n);
      n++;
      sn = sfalls(n);
      m_fall = (sn != sp);
      m_fs = m_fall && (sp % 64 == 63);
      m_xfer = sample_valid && m_ready;
      m_underrun = m_fs && !m_hf;
      if (m_fs && m_hf) begin
        m_active = m_hold;
        m_hf = 0;
      end
      if (m_xfer) begin
        m_hold = {sample_left, sample_right};
        m_hf = 1;
      end
      m_ready = !m_hf;
      if (m_fall) begin
        m_k  = int'(sn % 32);
        m_lr = int'((sn / 32) % 2);
        chan = (m_lr == 1) ? m_active[15:0] : m_active[31:16];
        m_dac = (m_k >= 1 && m_k <= 16 && !mute) ? chan[16 - m_k] : 1'b0;
      end
    end
    #1;
    if (reset)
      exp = '0;
    else
      exp = {(toggles(n) % 2) == 1, ((sfalls(n) / 32) % 2) == 1, m_dac, m_underrun, m_ready};
    chk("outs", {audio_mclk, audio_lrck, audio_dac, underrun, sample_ready}, exp);
    if (!reset) begin
      if (m_fall && m_k >= 1 && m_k <= 16) cap = {cap[14:0], audio_dac};
      if (m_fall && (m_k == 0 || m_k > 16) && audio_dac) zero_slot_ones++;
      if (m_fall && m_k == 17) begin
        if (m_lr == 0) last_left = cap;
        else played.push_back({last_left, cap});
      end
      if (underrun) ur_count++;
      if (audio_dac) dac_ones++;
      if (audio_mclk && !prev_mclk) mclk_rises++;
      if (!audio_lrck && prev_lrck) lrck_falls++;
      prev_mclk = audio_mclk;
      prev_lrck = audio_lrck;
    end
  endtask

  task automatic do_reset(input int cyc);
    reset = 1'b1;
    #1;
    chk("rst_async", {audio_mclk, audio_lrck, audio_dac, underrun, sample_ready}, 5'b0);
    repeat (cyc) step();
    chk("ready_in_reset", sample_ready, 1'b0);
    reset = 1'b0;
  endtask

  task automatic send_pair(input logic [31:0] p, input int budget);
    int w;
    sample_left = p[31:16];
    sample_right = p[15:0];
    sample_valid = 1'b1;
    w = 0;
    do begin step(); w++; end while (!m_xfer && w < budget);
    chk("xfer_timeout", m_xfer, 1'b1);
    sample_valid = 1'b0;
  endtask

  task automatic wait_played(input int cnt, input int budget);
    int w;
    w = 0;
    while (played.size() < cnt && w < budget) begin step(); w++; end
    chk("played_timeout", played.size() >= cnt, 1'b1);
  endtask

  initial begin
    logic [31:0] pairs[3];
    int w;
    logic [31:0] rp;

    model_reset();
    clear_stats();
    do_reset(3);

    // 1: idle run, ten frames, no samples
    clear_stats();
    repeat (15470) step();
    chk("t1_mclk_rises", mclk_rises, (toggles(15470) + 1) / 2);
    chk("t1_lrck_periods", lrck_falls, sfalls(15470) / 64);
    chk("t1_underruns", ur_count, sfalls(15470) / 64);
    chk("t1_dac_ones", dac_ones, 0);

    // 2: known pair before first frame start
    do_reset(3);
    clear_stats();
    send_pair(32'hA5C3_1234, 10);
    wait_played(2, 5000);
    chk("t2_frame0", played[0], 32'h0);
    chk("t2_left", played[1][31:16], 16'hA5C3);
    chk("t2_right", played[1][15:0], 16'h1234);
    chk("t2_zero_slots", zero_slot_ones, 0);
    chk("t2_underrun", ur_count, 0);

    // 3: three pairs back to back, each later one accepted right after a frame start
    clear_stats();
    for (int i = 0; i < 3; i++) pairs[i] = $urandom;
    sample_left = pairs[0][31:16];
    sample_right = pairs[0][15:0];
    sample_valid = 1'b1;
    step();
    chk("t3_first_immediate", m_xfer, 1'b1);
    for (int i = 1; i < 3; i++) begin
      logic seen_fs;
      sample_left = pairs[i][31:16];
      sample_right = pairs[i][15:0];
      seen_fs = 0;
      w = 0;
      do begin
        step(); w++;
        if (m_xfer) chk("t3_align", seen_fs, 1'b1);
        seen_fs = m_fs;
      end while (!m_xfer && w < 4000);
      chk("t3_xfer_timeout", m_xfer, 1'b1);
    end
    sample_valid = 1'b0;
    wait_played(3, 6000);
    for (int i = 0; i < 3; i++) chk("t3_order", played[i], pairs[i]);
    chk("t3_underrun", ur_count, 0);

    // 4: stop after 7FFF/8000; last pair repeats with one underrun per frame
    send_pair(32'h7FFF_8000, 10);
    clear_stats();
    wait_played(5, 9000);
    for (int i = 0; i < 5; i++) chk("t4_repeat", played[i], 32'h7FFF_8000);
    chk("t4_underruns", ur_count, 4);

    // 5: mute mid-slot 5 of left, release mid-slot 12
    w = 0;
    do begin step(); w++; end while (!(m_fall && m_lr == 0 && m_k == 5) && w < 4000);
    chk("t5_sync_timeout", m_fall, 1'b1);
    repeat (3) step();
    mute = 1'b1;
    w = 0;
    do begin step(); w++; end while (!(m_fall && m_k == 12) && w < 4000);
    repeat (3) step();
    mute = 1'b0;
    clear_stats();
    wait_played(1, 3000);
    chk("t5_left_muted", played[0][31:16], 16'h780F);
    chk("t5_right", played[0][15:0], 16'h8000);

    // random traffic with occasional mute toggles; the per-cycle model check judges it
    for (int c = 0; c < 12000; c++) begin
      if (!sample_valid && $urandom_range(0, 99) < 2) begin
        rp = $urandom;
        sample_left = rp[31:16];
        sample_right = rp[15:0];
        sample_valid = 1'b1;
      end
      if ($urandom_range(0, 499) == 0) mute = ~mute;
      step();
      if (m_xfer) sample_valid = 1'b0;
    end
    sample_valid = 1'b0;
    mute = 1'b0;

    // 6: reset in right-channel slot 9 with holding register full
    w = 0;
    do begin step(); w++; end while (!m_fs && w < 4000);
    chk("t6_fs_timeout", m_fs, 1'b1);
    send_pair($urandom, 10);
    w = 0;
    do begin step(); w++; end while (!(m_fall && m_lr == 1 && m_k == 9) && w < 3000);
    chk("t6_slot9_timeout", m_fall, 1'b1);
    chk("t6_hold_full", sample_ready, 1'b0);
    repeat (4) step();
    do_reset(3);
    clear_stats();
    step();
    chk("t6_ready_after", sample_ready, 1'b1);
    wait_played(2, 4000);
    chk("t6_frame0", played[0], 32'h0);
    chk("t6_frame1", played[1], 32'h0);
    chk("t6_underrun", ur_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
